fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the instruction ROM (7-bit word address, 8-bit instruction, combinational read).
//  - Owns the program counter; drives the ROM address; captures each returned instruction, tagged with its PC, into a 2-entry buffer.
//  - Hands instructions to decode over a valid/ready handshake.
//  - Handles redirects (branch/jump), back-pressure and the HALT opcode.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_ctrl.sv | 109 ++++++++++
 tb/tb_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction-fetch slice.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W   = 7;
  localparam int unsigned FETCH_INSTR_W  = 8;
  localparam logic [6:0]  FETCH_RESET_PC = 7'h00;
  localparam logic [7:0]  FETCH_HALT_OP  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order buffer between the ROM and decode.
// Entry 0 is always the head; it keeps its contents when the buffer empties
// so the head outputs hold their last value.
module fetch_fifo #(
  parameter int unsigned W = 15
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         full_o
);

  logic [W-1:0] entry0;
  logic [W-1:0] entry1;
  logic [1:0]   count;

  // Shift-register style storage: pops move entry 1 into the head slot.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= '0;
    end else if (flush_i) begin
      count <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push_i) begin
            entry0 <= data_i;
            count  <= 2'd1;
          end
        end
        2'd1: begin
          if (pop_i && push_i) begin
            entry0 <= data_i;
          end else if (pop_i) begin
            count <= 2'd0;
          end else if (push_i) begin
            entry1 <= data_i;
            count  <= 2'd2;
          end
        end
        default: begin
          if (pop_i) begin
            entry0 <= entry1;
            if (push_i) begin
              entry1 <= data_i;
            end else begin
              count <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign data_o  = entry0;
  assign valid_o = (count != 2'd0);
  assign full_o  = (count == 2'd2);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC register, fetch FSM and buffer control.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned        INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = FETCH_RESET_PC,
  parameter logic [INSTR_W-1:0] HALT_OP  = FETCH_HALT_OP
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  output logic [ADDR_W-1:0]  rom_addr_o,
  input  logic [INSTR_W-1:0] rom_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               halted_o,
  output logic               busy_o
);

  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_e        state;
  fetch_state_e        state_next;
  logic [ADDR_W-1:0]   pc;
  logic                push;
  logic                flush;
  logic                transfer;
  logic                buf_full;
  logic                buf_valid;
  logic [ENTRY_W-1:0]  buf_head;

  assign transfer = buf_valid && instr_ready_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, push/flush decisions and status outputs; redirect overrides everything.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_i) begin
      state_next = ST_FETCH;
      flush      = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state_next = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!buf_full || transfer) begin
            push = 1'b1;
            if (rom_data_i == HALT_OP) begin
              state_next = ST_HALTED;
            end
          end
        end
        default: begin
        end
      endcase
    end
    busy_o   = (state == ST_FETCH);
    halted_o = (state == ST_HALTED);
  end

  // Program counter: advances on each push except past a HALT word.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc <= RESET_PC;
    end else if (redirect_i) begin
      pc <= redirect_pc_i;
    end else if (push && (rom_data_i != HALT_OP)) begin
      pc <= pc + ADDR_W'(1);
    end
  end

  fetch_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .pop_i   (transfer),
    .flush_i (flush),
    .data_i  ({pc, rom_data_i}),
    .data_o  (buf_head),
    .valid_o (buf_valid),
    .full_o  (buf_full)
  );

  assign rom_addr_o    = pc;
  assign instr_o       = buf_head[INSTR_W-1:0];
  assign instr_pc_o    = buf_head[ENTRY_W-1:INSTR_W];
  assign instr_valid_o = buf_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected (pc, instr) pairs are queued when
// the bench sets up a fetch sequence and popped on every observed transfer.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] instr;
  logic [6:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       redirect;
  logic [6:0] redirect_pc;
  logic       halted;
  logic       busy;

  logic [7:0]  rom [128];
  logic [14:0] exp_q [$];
  int          checks   = 0;
  int          failures = 0;
  int          xfers    = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  fetch_ctrl #(
    .ADDR_W   (7),
    .INSTR_W  (8),
    .RESET_PC (7'h00),
    .HALT_OP  (8'hFF)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .halted_o      (halted),
    .busy_o        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 128; i++) rom[i] = 8'(i) ^ 8'h5A;
  endtask

  task automatic expect_word(input logic [6:0] pc);
    exp_q.push_back({pc, rom[pc]});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [6:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(halted), 32'd1);
    tick();
    tick();
    check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Transfer monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      logic [14:0] e;
      xfers++;
      check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("xfer_pc", 32'(instr_pc), 32'(e[14:8]));
        check_eq("xfer_instr", 32'(instr), 32'(e[7:0]));
      end
    end
  end

  initial begin
    int x0;
    rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    fill_rom();

    // 1: reset values, streaming at full rate
    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44; rom[4] = 8'hFF;
    do_reset();
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", 32'(instr), 32'd0);
    check_eq("rst_pc", 32'(instr_pc), 32'd0);
    check_eq("rst_addr", 32'(rom_addr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) expect_word(7'(i));
    pulse_start();
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_not_yet_valid", 32'(instr_valid), 32'd0);
    x0 = xfers;
    tick();
    check_eq("t1_first_valid", 32'(instr_valid), 32'd1);
    repeat (4) tick();
    check_eq("t1_rate", 32'(xfers - x0), 32'd4);
    wait_halted("t1_halt", 20);
    check_eq("t1_addr", 32'(rom_addr), 32'd4);

    // 2: back-pressure, then drain with no gap
    fill_rom(); rom[3] = 8'hFF;
    do_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) expect_word(7'(i));
    pulse_start();
    repeat (5) tick();
    check_eq("t2_stall_addr", 32'(rom_addr), 32'd2);
    check_eq("t2_hold_valid", 32'(instr_valid), 32'd1);
    check_eq("t2_hold_pc", 32'(instr_pc), 32'd0);
    instr_ready = 1'b1;
    x0 = xfers;
    repeat (4) tick();
    check_eq("t2_no_gap", 32'(xfers - x0), 32'd4);
    wait_halted("t2_halt", 10);
    check_eq("t2_addr", 32'(rom_addr), 32'd3);

    // 3: redirect with a full buffer and a same-cycle transfer
    fill_rom(); rom[8'h43] = 8'hFF;
    do_reset();
    instr_ready = 1'b0;
    expect_word(7'h00);
    pulse_start();
    tick();
    tick();
    check_eq("t3_full_addr", 32'(rom_addr), 32'd2);
    for (int i = 'h40; i < 'h44; i++) expect_word(7'(i));
    instr_ready = 1'b1;
    pulse_redirect(7'h40);
    check_eq("t3_gap", 32'(instr_valid), 32'd0);
    check_eq("t3_addr", 32'(rom_addr), 32'h40);
    tick();
    check_eq("t3_target_valid", 32'(instr_valid), 32'd1);
    check_eq("t3_target_pc", 32'(instr_pc), 32'h40);
    wait_halted("t3_halt", 20);

    // 4: HALT at 5, hold behaviour, redirect resumes
    fill_rom(); rom[5] = 8'hFF;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) expect_word(7'(i));
    pulse_start();
    wait_halted("t4_halt", 20);
    repeat (3) tick();
    check_eq("t4_addr_stuck", 32'(rom_addr), 32'd5);
    check_eq("t4_no_valid", 32'(instr_valid), 32'd0);
    check_eq("t4_pc_hold", 32'(instr_pc), 32'd5);
    check_eq("t4_instr_hold", 32'(instr), 32'hFF);
    for (int i = 0; i < 6; i++) expect_word(7'(i));
    pulse_redirect(7'h00);
    check_eq("t4_unhalt", 32'(halted), 32'd0);
    check_eq("t4_busy", 32'(busy), 32'd1);
    wait_halted("t4_rehalt", 20);

    // 5: PC wrap from 7F to 00
    rom[7'h7E] = 8'hA1; rom[7'h7F] = 8'hA2; rom[0] = 8'hA3; rom[1] = 8'hFF;
    expect_word(7'h7E); expect_word(7'h7F); expect_word(7'h00); expect_word(7'h01);
    pulse_redirect(7'h7E);
    wait_halted("t5_halt", 20);
    check_eq("t5_addr", 32'(rom_addr), 32'd1);

    // 6: reset mid-stream with a full buffer
    fill_rom(); rom[3] = 8'hFF;
    do_reset();
    instr_ready = 1'b0;
    pulse_start();
    repeat (4) tick();
    check_eq("t6_full_valid", 32'(instr_valid), 32'd1);
    rst_n = 1'b0; start = 1'b1; redirect = 1'b1; redirect_pc = 7'h33; instr_ready = 1'b1;
    tick();
    rst_n = 1'b1; start = 1'b0; redirect = 1'b0;
    check_eq("t6_valid", 32'(instr_valid), 32'd0);
    check_eq("t6_addr", 32'(rom_addr), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_instr", 32'(instr), 32'd0);
    repeat (3) tick();
    check_eq("t6_idle_valid", 32'(instr_valid), 32'd0);
    check_eq("t6_idle_addr", 32'(rom_addr), 32'd0);
    for (int i = 0; i < 4; i++) expect_word(7'(i));
    pulse_start();
    wait_halted("t6_halt", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
